program_counter: RTL and testbench

//   Fetch-stage PC register. Consumes the D-bit jump offset produced by the

---
 rtl/program_counter.sv | 123 ++++++++++++
 tb/tb_program_counter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Fetch-stage PC register with IDLE/RUN/HALTED run control and a saturating
// RUN-cycle counter. Every output comes straight from a flop.
module program_counter #(
   parameter int D = 12,
   parameter int C = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         halt,
   input  logic         stall,
   input  logic         branch_rel,
   input  logic         branch_abs,
   input  logic [D-1:0] target,
   output logic [D-1:0] prog_ctr,
   output logic         running,
   output logic         done,
   output logic [C-1:0] cycle_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [D-1:0] PC_ZERO  = {D{1'b0}};
   localparam logic [D-1:0] PC_ONE   = {{(D-1){1'b0}}, 1'b1};
   localparam logic [C-1:0] CNT_ZERO = {C{1'b0}};
   localparam logic [C-1:0] CNT_ONE  = {{(C-1){1'b0}}, 1'b1};
   localparam logic [C-1:0] CNT_MAX  = {C{1'b1}};

   state_t         state_q, state_d;
   logic [D-1:0]   pc_q, pc_d;
   logic [C-1:0]   cnt_q, cnt_d;
   logic           running_q, running_d;
   logic           done_q, done_d;
   logic [C-1:0]   cnt_sat_s;

   // Next-state, next-PC and counter logic; start outranks everything else.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      if (cnt_q == CNT_MAX) begin
         cnt_sat_s = CNT_MAX;
      end else begin
         cnt_sat_s = cnt_q + CNT_ONE;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = PC_ZERO;
               cnt_d   = CNT_ZERO;
            end else begin
               pc_d    = PC_ZERO;
            end
         end
         RUN: begin
            if (start) begin
               pc_d  = PC_ZERO;
               cnt_d = CNT_ZERO;
            end else begin
               // Halt and stall edges still count as executed cycles.
               cnt_d = cnt_sat_s;
               if (halt) begin
                  state_d = HALTED;
               end else if (stall) begin
                  pc_d = pc_q;
               end else if (branch_abs) begin
                  pc_d = target;
               end else if (branch_rel) begin
                  pc_d = pc_q + target;
               end else begin
                  pc_d = pc_q + PC_ONE;
               end
            end
         end
         HALTED: begin
            if (start) begin
               state_d = RUN;
               pc_d    = PC_ZERO;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = HALTED;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = PC_ZERO;
            cnt_d   = CNT_ZERO;
         end
      endcase

      running_d = (state_d == RUN);
      done_d    = (state_d == HALTED);
   end

   // State, PC, counter and status flags; async clear on reset_n.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pc_q      <= PC_ZERO;
         cnt_q     <= CNT_ZERO;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign prog_ctr  = pc_q;
   assign running   = running_q;
   assign done      = done_q;
   assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: behavioural model with per-cycle
// compare, directed scenarios with literal pins, then randomized stimulus.
module tb_program_counter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0, halt = 1'b0, stall = 1'b0;
   logic        branch_rel = 1'b0, branch_abs = 1'b0;
   logic [11:0] target = 12'd0;
   logic [11:0] prog_ctr, prog_ctr4;
   logic        running, done, running4, done4;
   logic [15:0] cycle_cnt;
   logic [3:0]  cycle_cnt4;

   int checks = 0;
   int failures = 0;

   // model: 0=idle 1=run 2=halted
   int m_state, m_pc, m_cnt, m_cnt4;

   program_counter #(.D(12), .C(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .halt(halt), .stall(stall),
      .branch_rel(branch_rel), .branch_abs(branch_abs), .target(target),
      .prog_ctr(prog_ctr), .running(running), .done(done), .cycle_cnt(cycle_cnt)
   );

   program_counter #(.D(12), .C(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start), .halt(halt), .stall(stall),
      .branch_rel(branch_rel), .branch_abs(branch_abs), .target(target),
      .prog_ctr(prog_ctr4), .running(running4), .done(done4), .cycle_cnt(cycle_cnt4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: start restarts from any state; otherwise only RUN advances.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_state <= 0; m_pc <= 0; m_cnt <= 0; m_cnt4 <= 0;
      end else if (start) begin
         m_state <= 1; m_pc <= 0; m_cnt <= 0; m_cnt4 <= 0;
      end else if (m_state == 1) begin
         m_cnt  <= (m_cnt  < 65535) ? m_cnt + 1  : 65535;
         m_cnt4 <= (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
         if (halt) m_state <= 2;
         else if (!stall) begin
            if (branch_abs)      m_pc <= target;
            else if (branch_rel) m_pc <= (m_pc + target) % 4096;
            else                 m_pc <= (m_pc + 1) % 4096;
         end
      end
   end

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("pc",      prog_ctr,   m_pc);
         chk("running", running,    m_state == 1);
         chk("done",    done,       m_state == 2);
         chk("cnt",     cycle_cnt,  m_cnt);
         chk("pc4",     prog_ctr4,  m_pc);
         chk("cnt4",    cycle_cnt4, m_cnt4);
         chk("done4",   done4,      m_state == 2);
         chk("running4",running4,   m_state == 1);
      end
   end

   // Apply one cycle of inputs (called just after a falling edge).
   task automatic cyc(input logic s, input logic h, input logic st,
                      input logic ba, input logic br, input logic [11:0] tg);
      start = s; halt = h; stall = st; branch_abs = ba; branch_rel = br; target = tg;
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk);
      start = 1'b0; halt = 1'b0; stall = 1'b0; branch_abs = 1'b0; branch_rel = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("idle_pc", prog_ctr, 0);
      chk("idle_running", running, 0);

      // idle ignores halt/branch
      cyc(0, 1, 0, 1, 0, 12'h055); chk("idle_hold_pc", prog_ctr, 0); settle();

      // start then 5 plain cycles
      cyc(1, 0, 0, 0, 0, 12'h000); chk("start_pc", prog_ctr, 0); chk("start_run", running, 1); settle();
      for (int i = 0; i < 5; i++) begin cyc(0, 0, 0, 0, 0, 12'h000); settle(); end
      chk("plain5_pc", prog_ctr, 5); chk("plain5_cnt", cycle_cnt, 5);

      // relative branches and wrap
      cyc(0, 0, 0, 1, 0, 12'h004); settle();
      cyc(0, 0, 0, 0, 1, 12'hFFB); chk("rel_m5_wrap", prog_ctr, 12'hFFF); settle();
      cyc(0, 0, 0, 0, 0, 12'h000); chk("inc_wrap", prog_ctr, 0); settle();
      cyc(0, 0, 0, 1, 0, 12'h004); settle();
      cyc(0, 0, 0, 0, 1, 12'hFFF); chk("rel_m1", prog_ctr, 3); settle();
      cyc(0, 0, 0, 1, 0, 12'h004); settle();
      cyc(0, 0, 0, 0, 1, 12'd20);  chk("rel_p20", prog_ctr, 24); settle();
      cyc(0, 0, 0, 0, 1, 12'h000); chk("rel_self", prog_ctr, 24); settle();

      // abs priority and stall
      cyc(0, 0, 0, 1, 0, 12'h007); settle();
      cyc(0, 0, 0, 1, 1, 12'h100); chk("abs_over_rel", prog_ctr, 12'h100); settle();
      cyc(0, 0, 0, 1, 0, 12'h007); settle();
      cyc(0, 0, 1, 1, 0, 12'h100); chk("stall_hold", prog_ctr, 7); settle();

      // halt, frozen, restart
      cyc(0, 0, 0, 1, 0, 12'h009); settle();
      cyc(0, 1, 0, 0, 0, 12'h000); chk("halt_done", done, 1); chk("halt_pc", prog_ctr, 9); settle();
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom)); settle();
      end
      chk("halted_pc", prog_ctr, 9); chk("halted_running", running, 0);
      cyc(1, 1, 0, 0, 0, 12'h000); chk("restart_pc", prog_ctr, 0); chk("restart_done", done, 0);
      chk("restart_cnt", cycle_cnt, 0); settle();

      // async reset mid-run at 0x37
      cyc(0, 0, 0, 1, 0, 12'h037); chk("pre_reset_pc", prog_ctr, 12'h037);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_pc", prog_ctr, 0); chk("rst_done", done, 0); chk("rst_cnt", cycle_cnt, 0);
      chk("rst_running", running, 0);
      settle();
      reset_n = 1'b1;
      cyc(0, 0, 0, 0, 0, 12'h000); chk("post_rst_idle", running, 0); chk("post_rst_pc", prog_ctr, 0); settle();

      // counter saturation in the narrow instance, start mid-run
      cyc(1, 0, 0, 0, 0, 12'h000); settle();
      for (int i = 0; i < 20; i++) begin cyc(0, 0, 0, 0, 0, 12'h000); settle(); end
      chk("sat_cnt4", cycle_cnt4, 15); chk("wide_cnt", cycle_cnt, 20); chk("sat_pc", prog_ctr, 20);
      cyc(1, 0, 0, 0, 0, 12'h000); chk("midrun_pc", prog_ctr, 0); chk("midrun_cnt4", cycle_cnt4, 0);
      chk("midrun_running", running, 1); settle();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 30) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), 12'($urandom));
         settle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
